// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART constants, state encodings and sizing helper for the transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int unsigned CLKS_PER_BIT_50M_115200 = 434;
  localparam int unsigned UART_DATA_W             = 8;
  localparam int unsigned UART_BIT_CNT_W          = 3;

  typedef enum logic [1:0] {
    SerIdle,
    SerStart,
    SerData,
    SerStop
  } ser_state_e;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbSend,
    ArbHold
  } arb_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_serializer.sv
// 8N1 serializer: start bit, eight data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
// A load on the final stop cycle chains the next frame with no idle bits.
module uart_tx_arbiter_serializer
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_50M_115200
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic [UART_DATA_W-1:0] i_data,
  output logic                   o_tx,
  output logic                   o_frame_done
);

  localparam int unsigned      BaudW    = cnt_width(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  ser_state_e                r_state;
  logic [BaudW-1:0]          r_baud;
  logic [UART_BIT_CNT_W-1:0] r_bit;
  logic [UART_DATA_W-1:0]    r_shift;
  logic                      r_tx;
  logic                      w_bit_end;

  assign w_bit_end    = (r_baud == BaudLast);
  assign o_frame_done = (r_state == SerStop) && w_bit_end;
  assign o_tx         = r_tx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SerIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else if (i_load) begin
      r_state <= SerStart;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= i_data;
      r_tx    <= 1'b0;
    end else begin
      case (r_state)
        SerIdle: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
        end
        SerStart: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= SerData;
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end
        SerData: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == '1) begin
              r_tx    <= 1'b1;
              r_state <= SerStop;
            end else begin
              r_bit   <= r_bit + UART_BIT_CNT_W'(1);
              r_shift <= {1'b0, r_shift[UART_DATA_W-1:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end
        SerStop: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= SerIdle;
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end
        default: r_state <= SerIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit line between NUM_REQ requesters: round-robin grant held for a
// whole message, with an optional timeout that breaks a lock whose owner stalls mid-message.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_50M_115200,
  parameter int unsigned HOLD_TIMEOUT = 65535
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   lock_timeout,
  output logic                   UART_TX
);

  localparam int unsigned      PtrW     = cnt_width(NUM_REQ);
  localparam int unsigned      HoldW    = cnt_width(HOLD_TIMEOUT + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TIMEOUT - 1);

  arb_state_e             r_state;
  logic [PtrW-1:0]        r_ptr;
  logic [PtrW-1:0]        r_owner;
  logic [NUM_REQ-1:0]     r_grant;
  logic                   r_last;
  logic [HoldW-1:0]       r_hold_cnt;

  logic [PtrW-1:0]        w_winner;
  logic [PtrW-1:0]        w_sel;
  logic [PtrW-1:0]        w_next_ptr;
  logic [NUM_REQ-1:0]     w_sel_onehot;
  logic [UART_DATA_W-1:0] w_sel_data;
  logic                   w_sel_last;
  logic                   w_found;
  logic                   w_accept;
  logic                   w_timeout;
  logic                   w_owner_valid;
  logic                   w_frame_done;

  assign w_owner_valid = req_valid[r_owner];
  assign w_next_ptr    = (r_owner == PtrW'(NUM_REQ - 1)) ? '0 : r_owner + PtrW'(1);

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    w_winner = r_ptr;
    w_found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[PtrW'(idx)]) begin
        w_found  = 1'b1;
        w_winner = PtrW'(idx);
      end
    end
  end

  always_comb begin
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    w_sel     = r_owner;
    case (r_state)
      ArbIdle: begin
        w_accept = w_found;
        w_sel    = w_winner;
      end
      ArbSend: w_accept = w_frame_done && !r_last && w_owner_valid;
      ArbHold: begin
        w_accept  = w_owner_valid;
        w_timeout = !w_owner_valid && (HOLD_TIMEOUT != 0) && (r_hold_cnt == HoldLast);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_sel_onehot = '0;
    w_sel_data   = '0;
    w_sel_last   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_sel == PtrW'(i)) begin
        w_sel_onehot[i] = 1'b1;
        w_sel_data      = req_data[8*i +: 8];
        w_sel_last      = req_last[i];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state    <= ArbIdle;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_last     <= 1'b0;
      r_hold_cnt <= '0;
    end else if (w_accept) begin
      r_state <= ArbSend;
      r_owner <= w_sel;
      r_grant <= w_sel_onehot;
      r_last  <= w_sel_last;
    end else begin
      case (r_state)
        ArbSend: begin
          if (w_frame_done) begin
            if (r_last) begin
              r_state <= ArbIdle;
              r_grant <= '0;
              r_ptr   <= w_next_ptr;
            end else begin
              r_state    <= ArbHold;
              r_hold_cnt <= '0;
            end
          end
        end
        ArbHold: begin
          if (w_timeout) begin
            r_state <= ArbIdle;
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
          end else begin
            r_hold_cnt <= r_hold_cnt + HoldW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = w_accept ? w_sel_onehot : '0;
  assign grant        = r_grant;
  assign busy         = (r_state != ArbIdle);
  assign lock_timeout = w_timeout;

  uart_tx_arbiter_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_serializer (
    .i_clk        (CLOCK_50),
    .i_rst_n      (reset),
    .i_load       (w_accept),
    .i_data       (w_sel_data),
    .o_tx         (UART_TX),
    .o_frame_done (w_frame_done)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, a UART line decoder and an
// expected-byte scoreboard, plus timing checks on back-to-back frames and the hold timeout.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CPB     = 8;
  localparam int unsigned HOLD    = 100;
  localparam int          FRAME   = 10 * CPB;
  localparam int          QDEPTH  = 1024;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset    = 1'b0;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 lock_timeout;
  logic                 UART_TX;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .CLKS_PER_BIT (CPB),
    .HOLD_TIMEOUT (HOLD)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .busy         (busy),
    .lock_timeout (lock_timeout),
    .UART_TX      (UART_TX)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int dec_cnt = 0;
  int multi_ready = 0;
  int stray_ready = 0;
  int to_cnt = 0;
  int to_cyc = 0;
  bit rst_seen = 1'b0;

  logic [7:0] exp_q[$];
  int         starts[$];
  logic [3:0] gq[$];

  logic [8:0] pend[NUM_REQ][QDEPTH];
  int         head[NUM_REQ];
  int         tail[NUM_REQ];

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] order;
    logic [2:0]  n;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_req(input int i, input logic [7:0] d, input logic l);
    pend[i][tail[i]] = {l, d};
    tail[i]++;
  endtask

  function automatic bit pend_empty();
    for (int i = 0; i < NUM_REQ; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(exp_q.size() == 0 && pend_empty() && !busy)) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: still %0d bytes outstanding after %0d cycles, expected 0",
               name, exp_q.size(), budget);
    end
  endtask

  task automatic wait_dec(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (n < budget && dec_cnt < target) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk(name, dec_cnt >= target, 1);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    #2 reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b1;
  endtask

  // Requester model: offers the head of each queue, retires it after a sampled handshake.
  initial begin : req_engine
    logic [NUM_REQ-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    forever begin
      @(negedge CLOCK_50);
      hs = req_valid & req_ready;
      if ($countones(req_ready) > 1) multi_ready++;
      if ((req_ready & ~req_valid) != '0) stray_ready++;
      @(posedge CLOCK_50);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i]) head[i]++;
        if (head[i] != tail[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = pend[i][head[i]][7:0];
          req_last[i]        = pend[i][head[i]][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  initial begin : rst_watch
    forever begin
      @(negedge reset);
      rst_seen = 1'b1;
    end
  end

  initial begin : to_watch
    forever begin
      @(negedge CLOCK_50);
      if (lock_timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
    end
  end

  // Line decoder: samples mid-bit, drops frames cut short by reset, checks against exp_q.
  initial begin : decoder
    logic       prev_tx;
    logic [7:0] b;
    logic [7:0] e;
    logic       sb_ok;
    logic [3:0] g;
    int         s;
    prev_tx = 1'b1;
    forever begin
      @(negedge CLOCK_50);
      if (reset && prev_tx && !UART_TX) begin
        s        = cyc;
        rst_seen = 1'b0;
        repeat (CPB / 2) @(negedge CLOCK_50);
        sb_ok = !UART_TX;
        g     = grant;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge CLOCK_50);
          b[k] = UART_TX;
        end
        repeat (CPB) @(negedge CLOCK_50);
        sb_ok = sb_ok && UART_TX;
        if (!rst_seen) begin
          dec_cnt++;
          starts.push_back(s);
          gq.push_back(g);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL uart_byte: got %02h (framing ok=%0d), expected no byte", b, sb_ok);
          end else begin
            e = exp_q.pop_front();
            if (b !== e || !sb_ok) begin
              errors++;
              $display("FAIL uart_byte: got %02h (framing ok=%0d), expected %02h (framing ok=1)",
                       b, sb_ok, e);
            end
          end
        end
      end
      prev_tx = UART_TX;
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    int         d0;
    int         n;
    int         gaps_bad;
    logic [7:0] d;

    vecs[0] = '{mask: 4'b1111, data: 32'h33323130, order: 32'h33323130, n: 3'd4};
    vecs[1] = '{mask: 4'b1111, data: 32'h33323130, order: 32'h33323130, n: 3'd4};
    vecs[2] = '{mask: 4'b1010, data: 32'hA300A100, order: 32'h0000A3A1, n: 3'd2};
    vecs[3] = '{mask: 4'b0101, data: 32'h00C200C0, order: 32'h0000C2C0, n: 3'd2};
    vecs[4] = '{mask: 4'b1001, data: 32'hD30000D0, order: 32'h0000D0D3, n: 3'd2};
    vecs[5] = '{mask: 4'b0001, data: 32'h000000E0, order: 32'h000000E0, n: 3'd1};
    vecs[6] = '{mask: 4'b0110, data: 32'h00F2F100, order: 32'h0000F2F1, n: 3'd2};

    // Reset values
    repeat (3) @(negedge CLOCK_50);
    chk("rst_uart_tx", UART_TX, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lock_timeout", lock_timeout, 0);
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Reset mid-frame: line returns high at once and the partial byte is dropped
    push_req(0, 8'h5A, 1'b1);
    n = 0;
    while (n < 20 && UART_TX !== 1'b0) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("t1_frame_started", UART_TX, 0);
    repeat (30) @(negedge CLOCK_50);
    #3 reset = 1'b0;
    #1 chk("t1_tx_high_on_reset", UART_TX, 1);
    #196;
    chk("t1_grant_in_reset", grant, 0);
    chk("t1_busy_in_reset", busy, 0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (2 * FRAME) @(negedge CLOCK_50);
    chk("t1_no_spurious_byte", dec_cnt, 0);
    chk("t1_grant_after", grant, 0);
    chk("t1_busy_after", busy, 0);

    // Single-byte round-robin vectors, starting from a freshly reset pointer
    do_reset();
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (vecs[v].mask[i]) push_req(i, vecs[v].data[8*i +: 8], 1'b1);
      for (int k = 0; k < int'(vecs[v].n); k++) exp_q.push_back(vecs[v].order[8*k +: 8]);
      wait_drain($sformatf("vec%0d_drain", v), 8 * FRAME);
      chk($sformatf("vec%0d_grant_idle", v), grant, 0);
    end

    // "Hi" from requester 0: back-to-back frames, grant held throughout
    starts.delete();
    gq.delete();
    push_req(0, 8'h48, 1'b0);
    push_req(0, 8'h69, 1'b1);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    wait_drain("t2_drain", 4 * FRAME);
    chk("t2_byte_count", starts.size(), 2);
    if (starts.size() >= 2) begin
      chk("t2_start_spacing", starts[1] - starts[0], FRAME);
      chk("t2_grant_byte0", gq[0], 4'b0001);
      chk("t2_grant_byte1", gq[1], 4'b0001);
    end
    chk("t2_grant_end", grant, 0);
    chk("t2_busy_end", busy, 0);

    // Requester 1 stalls mid-message; requester 2 must wait for the lock to clear
    push_req(1, 8'h41, 1'b0);
    push_req(2, 8'h42, 1'b1);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h42);
    d0 = dec_cnt;
    wait_dec("t4_first_byte", d0 + 1, 3 * FRAME);
    repeat (10) @(negedge CLOCK_50);
    chk("t4_hold_busy", busy, 1);
    chk("t4_hold_grant", grant, 4'b0010);
    chk("t4_hold_no_ready", req_ready, 0);
    chk("t4_hold_line_idle", UART_TX, 1);
    push_req(1, 8'h43, 1'b1);
    wait_drain("t4_drain", 6 * FRAME);
    chk("t4_no_timeout", to_cnt, 0);

    // Requester 3 stalls past the hold timeout; requester 0 follows after release
    starts.delete();
    push_req(3, 8'h55, 1'b0);
    push_req(0, 8'h30, 1'b1);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h30);
    d0 = dec_cnt;
    wait_dec("t5_first_byte", d0 + 1, 3 * FRAME);
    repeat (10) @(negedge CLOCK_50);
    chk("t5_hold_grant", grant, 4'b1000);
    chk("t5_hold_no_ready", req_ready, 0);
    wait_drain("t5_drain", 4 * FRAME + 2 * HOLD);
    chk("t5_timeout_pulses", to_cnt, 1);
    chk("t5_byte_count", starts.size(), 2);
    if (starts.size() >= 2) begin
      chk("t5_timeout_cycle", to_cyc, starts[0] + FRAME + HOLD - 1);
      chk("t5_next_start", starts[1], to_cyc + 2);
    end

    // All 256 byte values back-to-back from requester 2
    starts.delete();
    for (int k = 0; k < 256; k++) begin
      d = 8'(k * 37 + 11);
      push_req(2, d, (k == 255));
      exp_q.push_back(d);
    end
    wait_drain("t6_drain", 256 * FRAME + 4 * FRAME);
    chk("t6_byte_count", starts.size(), 256);
    gaps_bad = 0;
    for (int k = 1; k < starts.size(); k++)
      if (starts[k] - starts[k-1] != FRAME) gaps_bad++;
    chk("t6_frame_gaps", gaps_bad, 0);
    chk("t6_grant_end", grant, 0);
    chk("ready_multi_hot", multi_ready, 0);
    chk("ready_without_valid", stray_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the board's single UART transmit line between NUM_REQ on-chip requesters, for example the button/LED logic and a debug dumper. Each requester offers bytes on a valid/ready port and marks the last byte of a message. The block grants the line round-robin and holds the grant for a whole message, so messages never interleave. It serialises each byte as 8N1 at the configured baud onto UART_TX.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
CLKS_PER_BIT, 434, clock cycles per bit. 50 MHz / 115200 baud gives 434 cycles = 8680 ns per bit.
HOLD_TIMEOUT, 65535, idle cycles a grant holder may stall mid-message before the lock is forcibly released. 0 disables the timeout.

Ports:
CLOCK_50  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  per-requester byte valid.
req_data  in  8*NUM_REQ  flattened bytes; requester i uses bits [8i+7:8i].
req_last  in  NUM_REQ  byte is the final byte of its message.
req_ready  out  NUM_REQ  one-cycle accept pulse; the byte transfers when valid and ready are both high.
grant  out  NUM_REQ  one-hot current owner; all zero when no message is in progress.
busy  out  1  high while a frame is on the line or a lock is held.
lock_timeout  out  1  one-cycle pulse when HOLD_TIMEOUT expires.
UART_TX  out  1  serial line; idles high.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - UART_TX=1; req_ready=0; grant=0; busy=0; lock_timeout=0.
  - Round-robin pointer=0; FSM=IDLE.
  - Asserting reset mid-frame drives UART_TX high immediately and drops the partial byte.
- FSM states: IDLE, START, DATA, STOP, HOLD.
- IDLE, when any req_valid is high:
  - Winner = first valid index at or above the pointer, wrapping modulo NUM_REQ.
  - In the same cycle: req_ready[winner]=1, load req_data into the shift register, set grant to the winner and latch last=req_last.
  - Next state START.
- START: UART_TX=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles, then STOP.
- STOP: UART_TX=1 for CLKS_PER_BIT cycles. On the final STOP cycle:
  - If last=1: grant←0, pointer←(winner+1) mod NUM_REQ, next IDLE.
  - If last=0 and req_valid[owner]=1: accept the next byte on this cycle (ready pulse, load), next START. Back-to-back frames have no extra idle bits.
  - If last=0 and req_valid[owner]=0: next HOLD; grant and busy stay high.
- HOLD:
  - Only the owner may proceed. When req_valid[owner] rises, accept it that cycle and go to START.
  - Other requesters stay blocked.
  - If HOLD_TIMEOUT≠0 and HOLD lasts HOLD_TIMEOUT cycles: pulse lock_timeout, grant←0, pointer←owner+1, next IDLE.
- req_ready is never high for more than one requester, and never high outside the accept cycles above.
- Latency and frame timing:
  - UART_TX falls in the cycle after the accept cycle.
  - One frame = 10*CLKS_PER_BIT = 4340 cycles.
- Bit counter: 3 bits. Baud counter: clog2(CLKS_PER_BIT) bits; it reloads at each bit boundary and does not drift across frames.
- Single requester: behaviour is unchanged and the pointer wraps to the same index.
- Simultaneous valids in IDLE: exactly one winner, by pointer order.
- Requester changes req_data while valid and not ready: no effect. Data is sampled only on the accept cycle.
- busy = (state≠IDLE).

Decomposition:
- Shared include uart_defs.vh holds:
  - CLKS_PER_BIT_50M_115200=434 and the FSM state encodings.
  - Field-width macros reused by the existing uart design and the bench decoder.
- Sub-module uart_tx_serializer holds the START/DATA/STOP timing, shift register and baud counter.
  - Interface: load strobe, data[7:0], tx, and a frame_done strobe asserted on the final STOP cycle.
- The arbiter top keeps the pointer, lock, HOLD timer and the IDLE/HOLD states.

Test Plan:
1. Reset low for 200 ns mid-frame → UART_TX=1 within one cycle. After release, grant=0, busy=0, and the decoder prints nothing spurious.
2. Requester 0 sends "Hi" (0x48 last=0, 0x69 last=1) → decoder prints 0x48 then 0x69. The second start bit begins exactly 4340 cycles after the first. grant=0001 throughout, then 0000.
3. All four requesters assert valid with single-byte messages 0x30..0x33 (last=1) from reset → output order 0x30,0x31,0x32,0x33. Re-asserting all four gives the same order (pointer wrap).
4. Requester 1 sends 0x41 (last=0) then stalls, while requester 2 holds 0x42 valid → 0x42 is not sent. Requester 1's 0x43 (last=1) is sent next, then 0x42.
5. HOLD_TIMEOUT=100: requester 3 sends 0x55 (last=0) and stalls → lock_timeout pulses 100 cycles after STOP ends. Requester 0's pending 0x30 starts on the next IDLE.
6. Random data, all 256 byte values from requester 2 back-to-back → decoder matches every byte, and req_ready never has more than one bit set.
